// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing recovery: measures HS/VS timing, locks to a stable mode and
// emits pixel coordinates aligned with the sampled colour, 3 clocks after the pins.
module vga_sync_decoder #(
  parameter int CNT_W    = 12,
  parameter bit SYNC_POL = 1'b0,
  parameter int H_BACK   = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_BACK   = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic [7:0]       vga_r,
  input  logic [7:0]       vga_g,
  input  logic [7:0]       vga_b,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync_w,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync_w,
  output logic             locked,
  output logic             frame_start,
  output logic             pixel_valid,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic [7:0]       pix_r,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_BACK);
  localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_BACK);
  localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       rst_sync;
  logic             rst_i_n;
  logic [25:0]      pipe1, pipe2;
  logic             hs_prev, vs_prev;
  logic             hs_act, vs_act, hs_edge, vs_edge, hs_release, vs_release;
  logic [CNT_W-1:0] h_cnt_reg, h_cnt, line_cnt_reg, line_cnt;
  logic [CNT_W-1:0] last_period, period, new_h, new_v;
  logic [CNT_W-1:0] hs_w, vs_lines;
  logic             h_sat, h_err, h_bad, h_err_now, act;

  // Reset takes effect immediately but is released two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      pipe1   <= '0;
      pipe2   <= '0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      pipe1   <= {vga_hs, vga_vs, vga_r, vga_g, vga_b};
      pipe2   <= pipe1;
      hs_prev <= pipe2[25];
      vs_prev <= pipe2[24];
    end

  assign hs_act     = (pipe2[25] == SYNC_POL);
  assign vs_act     = (pipe2[24] == SYNC_POL);
  assign hs_edge    = hs_act && (hs_prev != SYNC_POL);
  assign vs_edge    = vs_act && (vs_prev != SYNC_POL);
  assign hs_release = !hs_act && (hs_prev == SYNC_POL);
  assign vs_release = !vs_act && (vs_prev == SYNC_POL);

  assign h_sat     = (h_cnt_reg == CNT_MAX);
  assign period    = h_cnt_reg + ONE;
  assign new_h     = hs_edge ? period : last_period;
  assign new_v     = line_cnt_reg + ONE;
  assign h_bad     = hs_edge && (state_reg != SEARCH) && (period != h_total);
  assign h_err_now = h_err || h_bad;

  // h_cnt/line_cnt are the positions of the sample currently in stage 2.
  always_comb begin
    h_cnt    = h_cnt_reg;
    line_cnt = line_cnt_reg;
    if (hs_edge)     h_cnt = '0;
    else if (!h_sat) h_cnt = h_cnt_reg + ONE;
    if (vs_edge)                                 line_cnt = '0;
    else if (hs_edge && line_cnt_reg != CNT_MAX) line_cnt = line_cnt_reg + ONE;
  end

  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      h_cnt_reg    <= '0;
      line_cnt_reg <= '0;
      last_period  <= '0;
      hs_w         <= '0;
      vs_lines     <= '0;
      h_sync_w     <= '0;
      v_sync_w     <= '0;
      h_total      <= '0;
      v_total      <= '0;
      h_err        <= 1'b0;
    end else begin
      h_cnt_reg    <= h_cnt;
      line_cnt_reg <= line_cnt;
      if (hs_edge) last_period <= period;
      if (hs_edge)                          hs_w <= ONE;
      else if (hs_act && hs_w != CNT_MAX)   hs_w <= hs_w + ONE;
      if (hs_release) h_sync_w <= hs_w;
      if (vs_edge)                                      vs_lines <= hs_edge ? ONE : '0;
      else if (vs_act && hs_edge && vs_lines != CNT_MAX) vs_lines <= vs_lines + ONE;
      if (vs_release) v_sync_w <= vs_lines;
      if (vs_edge) begin
        h_total <= new_h;
        v_total <= new_v;
        h_err   <= 1'b0;
      end else if (h_bad) begin
        h_err <= 1'b1;
      end
    end

  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) state_reg <= SEARCH;
    else          state_reg <= state_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEARCH: if (vs_edge) state_next = CHECK;
      CHECK:  if (vs_edge && new_v == v_total && new_h == h_total &&
                  new_v != '0 && new_h != '0 && !h_err_now)
                state_next = LOCKED;
      LOCKED: if (h_err_now || (vs_edge && new_v != v_total) || h_sat)
                state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state_reg == LOCKED);
  end

  assign act = locked && (h_cnt >= H_LO) && (h_cnt < H_HI) &&
               (line_cnt >= V_LO) && (line_cnt < V_HI);

  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
    end else begin
      pixel_valid <= act;
      frame_start <= vs_edge && locked;
      pixel_x     <= act ? (h_cnt - H_LO) : '0;
      pixel_y     <= act ? (line_cnt - V_LO) : '0;
      pix_r       <= act ? pipe2[23:16] : '0;
      pix_g       <= act ? pipe2[15:8] : '0;
      pix_b       <= act ? pipe2[7:0] : '0;
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down video mode; expected pixels come from
// the generated line/column position, expected lock behaviour from the mode history.
module tb_vga_sync_decoder;
  localparam int HB = 12, HA = 40, VB = 3, VA = 20;

  logic clk = 1'b0, rst_n = 1'b0;
  logic vga_hs = 1'b1, vga_vs = 1'b1;
  logic [7:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic [11:0] h_total, h_sync_w, v_total, v_sync_w, pixel_x, pixel_y;
  logic locked, frame_start, pixel_valid;
  logic [7:0] pix_r, pix_g, pix_b;

  vga_sync_decoder #(.CNT_W(12), .SYNC_POL(1'b0), .H_BACK(HB), .H_ACTIVE(HA),
                     .V_BACK(VB), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst_n(rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
    .locked(locked), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int drv_n = -1, mon_k, mon_ix;
  bit r_act[8], r_fs[8];
  logic [11:0] r_x[8], r_y[8];
  logic [23:0] r_rgb[8];
  bit check_pix = 1'b0;
  int pix_errs, valid_cnt, fs_cnt, drop_id, exp_drop;
  logic [11:0] first_x, first_y;
  logic prev_locked = 1'b0;

  function automatic logic [98:0] all_out();
    return {h_total, h_sync_w, v_total, v_sync_w, locked, frame_start, pixel_valid,
            pixel_x, pixel_y, pix_r, pix_g, pix_b};
  endfunction

  // Outputs at a negedge belong to the sample driven three posedges earlier.
  always @(negedge clk) begin
    mon_k = drv_n - 3;
    if (prev_locked === 1'b1 && locked === 1'b0) drop_id = mon_k;
    prev_locked = locked;
    if (check_pix && mon_k >= 0) begin
      mon_ix = mon_k % 8;
      if (locked !== 1'b1) pix_errs++;
      if (pixel_valid === 1'b1) begin
        if (valid_cnt == 0) begin first_x = pixel_x; first_y = pixel_y; end
        valid_cnt++;
      end
      if (pixel_valid !== r_act[mon_ix]) pix_errs++;
      else if (r_act[mon_ix]) begin
        if (pixel_x !== r_x[mon_ix] || pixel_y !== r_y[mon_ix] ||
            {pix_r, pix_g, pix_b} !== r_rgb[mon_ix]) pix_errs++;
      end else if (pixel_x !== 12'd0 || pixel_y !== 12'd0 || {pix_r, pix_g, pix_b} !== 24'd0)
        pix_errs++;
      if (frame_start !== r_fs[mon_ix]) pix_errs++;
      if (frame_start === 1'b1) fs_cnt++;
    end
  end

  task automatic push(input bit act, input logic [11:0] x, input logic [11:0] y,
                      input logic [23:0] rgb, input bit fs);
    drv_n++;
    r_act[drv_n % 8] = act; r_x[drv_n % 8] = x; r_y[drv_n % 8] = y;
    r_rgb[drv_n % 8] = rgb; r_fs[drv_n % 8] = fs;
  endtask

  task automatic drive_lines(input int ht, input int hsw, input int vsw,
                             input int l0, input int l1, input int stretch);
    for (int l = l0; l < l1; l++) begin
      int len;
      len = (l == stretch) ? ht + 1 : ht;
      for (int c = 0; c < len; c++) begin
        bit act;
        logic [23:0] rgb;
        @(posedge clk); #1;
        act = (l >= VB) && (l < VB + VA) && (c >= HB) && (c < HB + HA);
        rgb = act ? {8'(c - HB), 8'(l - VB), 8'hA5} : 24'($urandom);
        vga_hs = (c < hsw) ? 1'b0 : 1'b1;
        vga_vs = (l < vsw) ? 1'b0 : 1'b1;
        {vga_r, vga_g, vga_b} = rgb;
        push(act, 12'(c - HB), 12'(l - VB), rgb, (l == 0 && c == 0));
        if (l == stretch + 1 && c == 0) exp_drop = drv_n;
      end
    end
  endtask

  task automatic drive_frames(input int ht, input int hsw, input int vt, input int vsw,
                              input int n);
    for (int f = 0; f < n; f++) drive_lines(ht, hsw, vsw, 0, vt, -1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vga_hs = 1'b1; vga_vs = 1'b1;
      {vga_r, vga_g, vga_b} = 24'($urandom);
      push(1'b0, 12'd0, 12'd0, 24'd0, 1'b0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_out() !== 99'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out()); end
    rst_n = 1'b1;
    idle(5);
    @(negedge clk);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL reset_exit_locked got=%b want=0", locked); end
    $display("test_reset: outputs zero in reset, unlocked after release");
  endtask

  task automatic test_lock();
    drive_frames(64, 8, 26, 2, 2);
    @(negedge clk);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", locked); end
    drive_frames(64, 8, 26, 2, 1);
    @(negedge clk);
    total++;
    if ({locked, h_total, h_sync_w, v_total, v_sync_w} !== {1'b1, 12'd64, 12'd8, 12'd26, 12'd2}) begin
      bad++;
      $display("FAIL lock_values got lk=%b ht=%0d hs=%0d vt=%0d vs=%0d want lk=1 ht=64 hs=8 vt=26 vs=2",
               locked, h_total, h_sync_w, v_total, v_sync_w);
    end
    $display("test_lock: locked=%b h_total=%0d h_sync_w=%0d v_total=%0d v_sync_w=%0d",
             locked, h_total, h_sync_w, v_total, v_sync_w);
  endtask

  task automatic test_pixels(input int ht, input int hsw, input int vt, input int vsw);
    pix_errs = 0; valid_cnt = 0; fs_cnt = 0; first_x = '1; first_y = '1;
    check_pix = 1'b1;
    drive_frames(ht, hsw, vt, vsw, 1);
    check_pix = 1'b0;
    total++;
    if (pix_errs != 0) begin bad++; $display("FAIL pixel_stream errors=%0d want 0", pix_errs); end
    total++;
    if (valid_cnt != HA * VA) begin bad++; $display("FAIL pixel_count got=%0d want=%0d", valid_cnt, HA * VA); end
    total++;
    if (fs_cnt != 1) begin bad++; $display("FAIL frame_start_count got=%0d want=1", fs_cnt); end
    total++;
    if (first_x !== 12'd0 || first_y !== 12'd0) begin
      bad++; $display("FAIL first_pixel got x=%0d y=%0d want 0,0", first_x, first_y);
    end
    $display("test_pixels: line=%0d frame=%0d valid=%0d starts=%0d errors=%0d",
             ht, vt, valid_cnt, fs_cnt, pix_errs);
  endtask

  task automatic test_stretch();
    int sl;
    sl = $urandom_range(1, 20);
    drop_id = -1; exp_drop = -2;
    drive_lines(64, 8, 2, 0, 26, sl);
    @(negedge clk);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL stretch_unlock got=%b want=0", locked); end
    total++;
    if (drop_id != exp_drop) begin bad++; $display("FAIL stretch_drop_time got=%0d want=%0d", drop_id, exp_drop); end
    drive_frames(64, 8, 26, 2, 3);
    @(negedge clk);
    total++;
    if ({locked, h_total, v_total} !== {1'b1, 12'd64, 12'd26}) begin
      bad++; $display("FAIL stretch_relock got lk=%b ht=%0d vt=%0d want 1 64 26", locked, h_total, v_total);
    end
    $display("test_stretch: line %0d stretched, drop at %0d, relocked=%b", sl, drop_id, locked);
  endtask

  task automatic test_stall();
    idle(4096);
    @(negedge clk);
    total++;
    if ({locked, pixel_valid} !== 2'b00) begin
      bad++; $display("FAIL stall_unlock got lk=%b pv=%b want 0 0", locked, pixel_valid);
    end
    drive_frames(64, 8, 26, 2, 3);
    @(negedge clk);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL stall_relock got=%b want=1", locked); end
    $display("test_stall: HS idle 4096 clocks, relocked=%b", locked);
  endtask

  task automatic test_mode_switch();
    drive_frames(80, 10, 30, 3, 1);
    @(negedge clk);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL switch_unlock got=%b want=0", locked); end
    drive_frames(80, 10, 30, 3, 2);
    @(negedge clk);
    total++;
    if ({locked, h_total, h_sync_w, v_total, v_sync_w} !== {1'b1, 12'd80, 12'd10, 12'd30, 12'd3}) begin
      bad++;
      $display("FAIL switch_values got lk=%b ht=%0d hs=%0d vt=%0d vs=%0d want lk=1 ht=80 hs=10 vt=30 vs=3",
               locked, h_total, h_sync_w, v_total, v_sync_w);
    end
    $display("test_mode_switch: locked=%b h_total=%0d v_total=%0d", locked, h_total, v_total);
  endtask

  task automatic test_reset_mid();
    int rl;
    rl = $urandom_range(1, 20);
    drive_lines(80, 10, 3, 0, rl, -1);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (all_out() !== 99'd0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", all_out()); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_lines(80, 10, 3, rl, 30, -1);
    drive_frames(80, 10, 30, 3, 3);
    @(negedge clk);
    total++;
    if ({locked, h_total, h_sync_w, v_total, v_sync_w} !== {1'b1, 12'd80, 12'd10, 12'd30, 12'd3}) begin
      bad++;
      $display("FAIL midreset_relock got lk=%b ht=%0d hs=%0d vt=%0d vs=%0d want lk=1 ht=80 hs=10 vt=30 vs=3",
               locked, h_total, h_sync_w, v_total, v_sync_w);
    end
    $display("test_reset_mid: reset at line %0d, relocked=%b h_total=%0d v_total=%0d",
             rl, locked, h_total, v_total);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixels(64, 8, 26, 2);
    test_stretch();
    test_stall();
    test_mode_switch();
    test_pixels(80, 10, 30, 3);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
